mmio_mem_ctrl: RTL
==================

MMIO_MEM_CTRL -- requirements
Module: mmio_mem_ctrl

Interface
REQ-001 SHALL have parameter LCD_DEPTH, default 8: LCD write-FIFO depth in words; power of two, minimum 2.
REQ-002 SHALL have parameter MMIO_BASE, default 12'hF00: lowest MMIO address; addresses below it map to dmem.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mem_address, input, 12 bits: processor M-stage data address.
REQ-006 SHALL have port mem_data_in, input, 32 bits: processor store data.
REQ-007 SHALL have port mem_wren, input, 1 bit: store strobe.
REQ-008 SHALL have port mem_rden, input, 1 bit: load strobe.
REQ-009 SHALL have port mem_data_out, output, 32 bits: load data, valid one cycle after mem_rden.
REQ-010 SHALL have port dmem_address, output, 12 bits: address to the synchronous data RAM.
REQ-011 SHALL have port dmem_data, output, 32 bits: RAM write data.
REQ-012 SHALL have port dmem_wren, output, 1 bit: RAM write enable.
REQ-013 SHALL have port dmem_q, input, 32 bits: RAM read data, one-cycle latency.
REQ-014 SHALL have port ps2_key_pressed, input, 1 bit: keyboard strobe.
REQ-015 SHALL have port ps2_out, input, 8 bits: keyboard scan code.
REQ-016 SHALL have port lcd_ready, input, 1 bit: LCD accepts a word this cycle.
REQ-017 SHALL have port lcd_write, output, 1 bit: one-cycle LCD write pulse.
REQ-018 SHALL have port lcd_data, output, 32 bits: word accompanying lcd_write.

Function
REQ-019 SHALL decode the address map: below MMIO_BASE = dmem; MMIO_BASE+0 = LCD data (write-only); +1 = LCD status (read); +2 = PS2 key (read); +3 = PS2 status (read); any other MMIO address reads 0; writes to it are ignored.
REQ-020 SHALL drive dmem_address = mem_address, dmem_data = mem_data_in combinationally, and dmem_wren = mem_wren only for dmem-range addresses.
REQ-021 SHALL register the read source selected by mem_address/mem_rden and the MMIO read value, so that mem_data_out presents dmem_q or the MMIO value exactly one cycle after mem_rden; mem_data_out = 0 in a cycle following no read.
REQ-022 SHALL push mem_data_in into the LCD FIFO on a write to MMIO_BASE+0 when count < LCD_DEPTH, or when count = LCD_DEPTH and a pop occurs in the same cycle.
REQ-023 SHALL drop a push that is not accepted and set sticky bit lcd_ovf.
REQ-024 SHALL pop the FIFO head whenever count > 0 and lcd_ready = 1, asserting lcd_write for that cycle with lcd_data = head; lcd_write = 0 and lcd_data = 0 otherwise.
REQ-025 SHALL wrap read/write pointers modulo LCD_DEPTH and keep count within 0..LCD_DEPTH; simultaneous push and pop on a non-empty FIFO SHALL leave count unchanged.
REQ-026 SHALL return LCD status = {23'b0, lcd_ovf, full, empty, count[5:0]} (count zero-extended) and SHALL clear lcd_ovf on that read, unless an overflow occurs in the same cycle.
REQ-027 SHALL register ps2_key_pressed once and detect a rising edge (0->1) between consecutive samples; on an edge, SHALL latch ps2_out into key_reg and set key_pending.
REQ-028 SHALL set sticky bit key_lost when an edge arrives while key_pending = 1; the new code overwrites key_reg.
REQ-029 SHALL return PS2 key read = {24'b0, key_reg} and clear key_pending; if an edge coincides with the read, the read returns the old key_reg, the new code is latched and key_pending stays 1.
REQ-030 SHALL return PS2 status = {30'b0, key_lost, key_pending} and clear key_lost on that read.
REQ-031 SHALL give priority to mem_wren when mem_wren and mem_rden are both asserted for the same MMIO address: the write is performed and the read returns 0.

Reset
REQ-032 SHALL, on reset, asynchronously clear the FIFO pointers, count, lcd_ovf, key_reg, key_pending, key_lost, the edge-detect sample and the read-select register.
REQ-033 SHALL hold mem_data_out = 0, lcd_write = 0, lcd_data = 0 and dmem_wren = 0 while reset = 1.
REQ-034 SHALL discard FIFO contents on reset asserted mid-operation, with no lcd_write pulse until new data is pushed.

Verification
REQ-035 SHALL be verified as follows: store 0xDEAD to 0x010, then load 0x010 -> dmem_wren pulses once; mem_data_out = 0xDEAD one cycle after the load.
REQ-036 SHALL be verified as follows: lcd_ready = 0, nine stores to 0xF00 with values 1..9 -> status read = 0x00000188 (ovf = 1, full = 1, count = 8); a second status read shows ovf = 0.
REQ-037 SHALL be verified as follows: raise lcd_ready with the FIFO full -> lcd_write high for 8 consecutive cycles, lcd_data = 1..8 in order, then empty = 1.
REQ-038 SHALL be verified as follows: two ps2 edges with codes 0x1C then 0x32 and no read in between -> PS2 status = 0x3; key read = 0x32; PS2 status then = 0x0.
REQ-039 SHALL be verified as follows: a ps2 edge in the same cycle as a key read -> the read returns the old code and key_pending remains 1.
REQ-040 SHALL be verified as follows: reset pulsed with 3 words queued and lcd_ready = 1 -> lcd_write = 0 immediately and after release; status read = 0x00000040 (empty).

Source files
------------

// File: rtl/mmio_mem_ctrl.sv
// Memory-mapped I/O controller: routes processor loads/stores to the data RAM,
// an LCD write FIFO and a PS/2 keyboard latch, with one-cycle load latency.
module mmio_mem_ctrl #(
    parameter int          LCD_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] mem_address,
    input  logic [31:0] mem_data_in,
    input  logic        mem_wren,
    input  logic        mem_rden,
    output logic [31:0] mem_data_out,
    output logic [11:0] dmem_address,
    output logic [31:0] dmem_data,
    output logic        dmem_wren,
    input  logic [31:0] dmem_q,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    input  logic        lcd_ready,
    output logic        lcd_write,
    output logic [31:0] lcd_data
);

    localparam int PW = (LCD_DEPTH > 1) ? $clog2(LCD_DEPTH) : 1;
    localparam int CW = $clog2(LCD_DEPTH + 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DMEM = 2'd1,
        SEL_MMIO = 2'd2
    } rd_sel_t;

    // Address decode
    logic        is_mmio;
    logic [11:0] mmio_off;
    logic        rd_mmio;
    logic        rd_lcd_stat;
    logic        rd_key;
    logic        rd_ps2_stat;

    assign is_mmio     = (mem_address >= MMIO_BASE);
    assign mmio_off    = mem_address - MMIO_BASE;
    // A store to the same MMIO address wins: the load is suppressed along with its side effects.
    assign rd_mmio     = mem_rden && is_mmio && !mem_wren;
    assign rd_lcd_stat = rd_mmio && (mmio_off == 12'd1);
    assign rd_key      = rd_mmio && (mmio_off == 12'd2);
    assign rd_ps2_stat = rd_mmio && (mmio_off == 12'd3);

    assign dmem_address = mem_address;
    assign dmem_data    = mem_data_in;
    assign dmem_wren    = mem_wren && !is_mmio && !reset;

    // LCD FIFO
    logic [31:0]   fifo_mem [LCD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          lcd_ovf;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_evt;
    logic [5:0]    count6;
    logic [31:0]   lcd_status;

    assign full       = (count == CW'(LCD_DEPTH));
    assign empty      = (count == '0);
    assign push_req   = mem_wren && is_mmio && (mmio_off == 12'd0);
    assign pop        = !empty && lcd_ready;
    assign push       = push_req && (!full || pop);
    assign ovf_evt    = push_req && !push;
    assign count6     = 6'(count);
    assign lcd_status = {23'b0, lcd_ovf, full, empty, count6};

    // LCD handshake: a word transfers in every cycle where lcd_write and lcd_ready
    // are both high; lcd_write only rises while lcd_ready is high and data is queued.
    assign lcd_write = pop && !reset;
    assign lcd_data  = lcd_write ? fifo_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lcd_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (ovf_evt) begin
                lcd_ovf <= 1'b1;
            end else if (rd_lcd_stat) begin
                lcd_ovf <= 1'b0;
            end
        end
    end

    // PS/2 keyboard latch
    logic       ps2_q;
    logic       ps2_edge;
    logic [7:0] key_reg;
    logic       key_pending;
    logic       key_lost;

    assign ps2_edge = ps2_key_pressed && !ps2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_q       <= 1'b0;
            key_reg     <= 8'd0;
            key_pending <= 1'b0;
            key_lost    <= 1'b0;
        end else begin
            ps2_q <= ps2_key_pressed;
            if (ps2_edge) begin
                key_reg     <= ps2_out;
                key_pending <= 1'b1;
            end else if (rd_key) begin
                key_pending <= 1'b0;
            end
            if (ps2_edge && key_pending) begin
                key_lost <= 1'b1;
            end else if (rd_ps2_stat) begin
                key_lost <= 1'b0;
            end
        end
    end

    // Load path: the MMIO value is captured with pre-update state in the read cycle.
    logic [31:0] mmio_rdata;
    logic [31:0] mmio_q;
    rd_sel_t     rd_sel;

    always_comb begin
        mmio_rdata = 32'd0;
        if (rd_lcd_stat) begin
            mmio_rdata = lcd_status;
        end else if (rd_key) begin
            mmio_rdata = {24'b0, key_reg};
        end else if (rd_ps2_stat) begin
            mmio_rdata = {30'b0, key_lost, key_pending};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_sel <= SEL_NONE;
            mmio_q <= 32'd0;
        end else begin
            mmio_q <= mmio_rdata;
            if (mem_rden && !is_mmio) begin
                rd_sel <= SEL_DMEM;
            end else if (mem_rden) begin
                rd_sel <= SEL_MMIO;
            end else begin
                rd_sel <= SEL_NONE;
            end
        end
    end

    always_comb begin
        mem_data_out = 32'd0;
        if (!reset) begin
            case (rd_sel)
                SEL_DMEM: mem_data_out = dmem_q;
                SEL_MMIO: mem_data_out = mmio_q;
                default:  mem_data_out = 32'd0;
            endcase
        end
    end

endmodule
